// File: rtl/pkt_history_prepend_if.sv
// AXI4-Stream bundle shared by the input and output sides of pkt_history_prepend.
interface pkt_history_prepend_if #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/pkt_history_prepend.sv
// Prepends header beats carrying the last HISTORY_DEPTH flow tuples to every packet,
// then passes the packet through and records its tuple in a ring buffer.
module pkt_history_prepend #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned TUPLE_WIDTH          = 112,
  parameter int unsigned HISTORY_DEPTH        = 16
) (
  input  logic                       axis_aclk,
  input  logic                       reset,
  pkt_history_prepend_if.slave       s_axis,
  pkt_history_prepend_if.master      m_axis,
  input  logic [TUPLE_WIDTH-1:0]     s_tuple,
  input  logic                       s_tuple_valid,
  output logic                       s_tuple_ready,
  input  logic                       hist_en,
  input  logic                       hist_clear,
  output logic [31:0]                hdr_pkt_count
);

  localparam int unsigned DW        = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned TPB       = DW / TUPLE_WIDTH;
  localparam int unsigned HDR_BEATS = (HISTORY_DEPTH + TPB - 1) / TPB;
  localparam int unsigned PW        = $clog2(HISTORY_DEPTH);
  localparam int unsigned BCW       = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int unsigned META_BASE = TPB * TUPLE_WIDTH;
  localparam logic [BCW-1:0] LastBeat = BCW'(HDR_BEATS - 1);
  localparam logic [PW:0]    Full     = (PW + 1)'(HISTORY_DEPTH);

  if (C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH ||
      C_S_AXIS_TUSER_WIDTH != C_M_AXIS_TUSER_WIDTH ||
      DW < META_BASE + 17 || HISTORY_DEPTH < 2 || HISTORY_DEPTH > 256 ||
      (HISTORY_DEPTH & (HISTORY_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("pkt_history_prepend: invalid parameter set");
  end

  typedef enum logic [1:0] {StIdle, StHdr, StPass} state_e;

  state_e                 r_state, w_state_next;
  logic [BCW-1:0]         r_beat;
  logic [31:0]            r_hdr_cnt;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW:0]            r_count;
  logic [TUPLE_WIDTH-1:0] r_mem [HISTORY_DEPTH];
  logic [DW-1:0]          w_hdr;
  logic                   w_hdr_fire;
  logic                   w_commit;

  assign hdr_pkt_count = r_hdr_cnt;

  // Header beat r_beat: TPB ring slots, plus pointer/fill metadata on beat 0 only.
  always_comb begin
    w_hdr = '0;
    for (int unsigned s = 0; s < TPB; s++) begin
      if ((32'(r_beat) * TPB + s) < HISTORY_DEPTH) begin
        w_hdr[s*TUPLE_WIDTH +: TUPLE_WIDTH] = r_mem[PW'(32'(r_beat) * TPB + s)];
      end
    end
    if (r_beat == '0) begin
      w_hdr[META_BASE +: 8]     = 8'(r_wr_ptr);
      w_hdr[META_BASE + 8 +: 9] = 9'(r_count);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = '0;
    m_axis.tkeep  = '0;
    m_axis.tuser  = '0;
    m_axis.tlast  = 1'b0;
    s_axis.tready = 1'b0;
    s_tuple_ready = 1'b0;
    w_hdr_fire    = 1'b0;
    w_commit      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (s_axis.tvalid && s_tuple_valid) begin
          w_state_next = hist_en ? StHdr : StPass;
        end
      end
      StHdr: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = w_hdr;
        m_axis.tkeep  = '1;
        m_axis.tuser  = s_axis.tuser;
        if (m_axis.tready) begin
          w_hdr_fire = 1'b1;
          if (r_beat == LastBeat) w_state_next = StPass;
        end
      end
      StPass: begin
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tdata  = s_axis.tdata;
        m_axis.tkeep  = s_axis.tkeep;
        m_axis.tuser  = s_axis.tuser;
        m_axis.tlast  = s_axis.tlast;
        s_axis.tready = m_axis.tready;
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
          w_commit      = 1'b1;
          s_tuple_ready = 1'b1;
          w_state_next  = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_beat    <= '0;
      r_hdr_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle) begin
        r_beat <= '0;
      end else if (w_hdr_fire) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_hdr_fire && r_beat == LastBeat) r_hdr_cnt <= r_hdr_cnt + 32'd1;
    end
  end

  // Clear has priority over a coinciding commit; the tuple is still popped.
  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(HISTORY_DEPTH); i++) r_mem[i] <= '0;
    end else if (hist_clear) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(HISTORY_DEPTH); i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[r_wr_ptr] <= s_tuple;
      r_wr_ptr        <= r_wr_ptr + 1'b1;
      if (r_count != Full) r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_history_prepend.sv
// Directed bench: default 512/112/16 instance plus a 256/112/4 instance for mid-packet reset.
module tb_pkt_history_prepend;

  localparam int DW  = 512;
  localparam int TW  = 112;
  localparam int HD  = 16;
  localparam int TPB = 4;
  localparam int HB  = 4;
  localparam int MB  = 448;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  pkt_history_prepend_if #(.DATA_WIDTH(512), .TUSER_WIDTH(128)) sa ();
  pkt_history_prepend_if #(.DATA_WIDTH(512), .TUSER_WIDTH(128)) ma ();
  pkt_history_prepend_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) sb ();
  pkt_history_prepend_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) mb ();

  logic [TW-1:0] tup_a, tup_b;
  logic          tv_a, tr_a, tv_b, tr_b, en_a, en_b, clr_a, clr_b;
  logic [31:0]   cnt_a, cnt_b;

  pkt_history_prepend #(
    .C_S_AXIS_DATA_WIDTH(512), .C_M_AXIS_DATA_WIDTH(512),
    .C_S_AXIS_TUSER_WIDTH(128), .C_M_AXIS_TUSER_WIDTH(128),
    .TUPLE_WIDTH(112), .HISTORY_DEPTH(16)
  ) u_dut_a (
    .axis_aclk(clk), .reset(rst_a), .s_axis(sa), .m_axis(ma),
    .s_tuple(tup_a), .s_tuple_valid(tv_a), .s_tuple_ready(tr_a),
    .hist_en(en_a), .hist_clear(clr_a), .hdr_pkt_count(cnt_a)
  );

  pkt_history_prepend #(
    .C_S_AXIS_DATA_WIDTH(256), .C_M_AXIS_DATA_WIDTH(256),
    .C_S_AXIS_TUSER_WIDTH(128), .C_M_AXIS_TUSER_WIDTH(128),
    .TUPLE_WIDTH(112), .HISTORY_DEPTH(4)
  ) u_dut_b (
    .axis_aclk(clk), .reset(rst_b), .s_axis(sb), .m_axis(mb),
    .s_tuple(tup_b), .s_tuple_valid(tv_b), .s_tuple_ready(tr_b),
    .hist_en(en_b), .hist_clear(clr_b), .hdr_pkt_count(cnt_b)
  );

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] m_hist [HD];
  int            m_ptr, m_cnt, m_hdrs;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] tv(input int i);
    return {14{8'(8'hA0 + i)}};
  endfunction

  function automatic logic [DW-1:0] dat(input int p, input int b);
    return {16{32'(p * 256 + b)}};
  endfunction

  function automatic logic [DW-1:0] exp_hdr(input int b);
    logic [DW-1:0] r;
    r = '0;
    for (int s = 0; s < TPB; s++) begin
      int idx;
      idx = b * TPB + s;
      if (idx < HD) r[s*TW +: TW] = m_hist[idx];
    end
    if (b == 0) begin
      r[MB +: 8]     = 8'(m_ptr);
      r[MB + 8 +: 9] = 9'(m_cnt);
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < HD; i++) m_hist[i] = '0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // One packet on DUT A; entered and left at posedge+1, outputs sampled at the negedge.
  task automatic run_pkt(input int pid, input int nb, input logic [TW-1:0] t, input logic en,
                         input logic rnd, input logic clr);
    int hb = 0;
    int db = 0;
    int guard = 0;
    logic [127:0] usr;
    usr = {4{32'(pid)}};
    tup_a = t; tv_a = 1'b1; en_a = en;
    sa.tvalid = 1'b1; sa.tuser = usr;
    sa.tdata = dat(pid, 0); sa.tlast = (nb == 1);
    sa.tkeep = (nb == 1) ? 64'h0000_0000_FFFF_FFFF : '1;
    while (db < nb && guard < 300) begin
      ma.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      if (guard == 0) begin
        chk("idle_tvalid", ma.tvalid, 1'b0);
        chk("idle_s_tready", sa.tready, 1'b0);
      end else if (en && hb < HB) begin
        chk("hdr_tvalid", ma.tvalid, 1'b1);
        chk("hdr_tdata", ma.tdata, exp_hdr(hb));
        chk("hdr_tuser", ma.tuser, usr);
        chk("hdr_tkeep", ma.tkeep, {64{1'b1}});
        chk("hdr_tlast", ma.tlast, 1'b0);
        chk("hdr_s_tready", sa.tready, 1'b0);
        if (ma.tready) hb++;
      end else begin
        chk("pass_tvalid", ma.tvalid, 1'b1);
        chk("pass_tdata", ma.tdata, dat(pid, db));
        chk("pass_tlast", ma.tlast, (db == nb - 1));
        chk("pass_tkeep", ma.tkeep, (db == nb - 1) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}});
        chk("pass_s_tready", sa.tready, ma.tready);
        if (ma.tready) begin
          if (db == nb - 1) begin
            chk("tuple_pop", tr_a, 1'b1);
            if (clr) clr_a = 1'b1;
          end else begin
            chk("no_pop", tr_a, 1'b0);
          end
          db++;
        end
      end
      @(posedge clk);
      #1;
      clr_a = 1'b0;
      if (db < nb) begin
        sa.tdata = dat(pid, db);
        sa.tlast = (db == nb - 1);
        sa.tkeep = (db == nb - 1) ? 64'h0000_0000_FFFF_FFFF : '1;
      end
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      errors++;
      $error("FAIL pkt_timeout: pid %0d stuck, observed %0d beats expected %0d", pid, db, nb);
    end
    sa.tvalid = 1'b0; sa.tlast = 1'b0; tv_a = 1'b0;
    if (en) m_hdrs++;
    if (clr) begin
      model_clear();
    end else begin
      m_hist[m_ptr] = t;
      m_ptr = (m_ptr + 1) % HD;
      if (m_cnt < HD) m_cnt++;
    end
    chk("hdr_pkt_count", cnt_a, 32'(m_hdrs));
  endtask

  initial begin
    logic [255:0] e;
    sa.tvalid = 1'b0; sa.tdata = '0; sa.tkeep = '0; sa.tuser = '0; sa.tlast = 1'b0;
    sb.tvalid = 1'b0; sb.tdata = '0; sb.tkeep = '0; sb.tuser = '0; sb.tlast = 1'b0;
    ma.tready = 1'b1; mb.tready = 1'b1;
    tup_a = '0; tup_b = '0; tv_a = 1'b0; tv_b = 1'b0;
    en_a = 1'b0; en_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    model_clear();
    m_hdrs = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", ma.tvalid, 1'b0);
    chk("rst_s_tready", sa.tready, 1'b0);
    chk("rst_tuple_ready", tr_a, 1'b0);
    chk("rst_hdr_count", cnt_a, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk);
    #1;

    // First packet sees an empty history; then fill the ring past wrap.
    run_pkt(1, 3, tv(0), 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) run_pkt(1 + i, 1, tv(i), 1'b1, 1'b0, 1'b0);
    run_pkt(18, 5, tv(17), 1'b1, 1'b1, 1'b0);

    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    model_clear();

    run_pkt(19, 2, tv(18), 1'b0, 1'b0, 1'b0);
    run_pkt(20, 1, tv(19), 1'b0, 1'b0, 1'b0);
    run_pkt(21, 2, tv(20), 1'b1, 1'b0, 1'b1);
    run_pkt(22, 1, tv(21), 1'b1, 1'b1, 1'b0);

    // Small instance: one complete packet, then reset in the middle of the next.
    sb.tvalid = 1'b1; sb.tlast = 1'b1; sb.tdata = {8{32'hB0B0_0001}};
    sb.tkeep = '1; sb.tuser = 128'h11;
    tup_b = tv(40); tv_b = 1'b1; en_b = 1'b1;
    #4;
    chk("b_idle_tvalid", mb.tvalid, 1'b0);
    @(posedge clk); #5;
    chk("b_hdr0_empty", mb.tdata, '0);
    @(posedge clk); #5;
    chk("b_hdr1_empty", mb.tdata, '0);
    @(posedge clk); #5;
    chk("b_pass_tdata", mb.tdata, {8{32'hB0B0_0001}});
    chk("b_pop", tr_b, 1'b1);
    @(posedge clk); #1;
    sb.tlast = 1'b0; sb.tdata = {8{32'hB0B0_0002}}; tup_b = tv(41);
    #4;
    chk("b_idle2_tvalid", mb.tvalid, 1'b0);
    e = '0;
    e[111:0]   = tv(40);
    e[231:224] = 8'd1;
    e[240:232] = 9'd1;
    @(posedge clk); #5;
    chk("b_hdr0_one", mb.tdata, e);
    chk("b_hdr_count", cnt_b, 32'd1);
    @(posedge clk); #5;
    chk("b_hdr1_zero", mb.tdata, '0);
    @(posedge clk); #5;
    chk("b_pass2_tvalid", mb.tvalid, 1'b1);
    chk("b_pass2_tdata", mb.tdata, {8{32'hB0B0_0002}});
    chk("b_pass2_ready", sb.tready, 1'b1);
    chk("b_pass2_nopop", tr_b, 1'b0);
    #1 rst_b = 1'b1;
    #1;
    chk("b_rst_tvalid", mb.tvalid, 1'b0);
    chk("b_rst_s_tready", sb.tready, 1'b0);
    chk("b_rst_hdr_count", cnt_b, 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    #4;
    chk("b_post_rst_idle", mb.tvalid, 1'b0);
    @(posedge clk); #5;
    chk("b_post_rst_tvalid", mb.tvalid, 1'b1);
    chk("b_post_rst_hdr0", mb.tdata, '0);
    sb.tvalid = 1'b0; tv_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_history_prepend.md
# pkt_history_prepend

Parametrised flow-history prepender for the AXI4-Stream datapath. Before each packet it emits a configurable number of header beats holding the last HISTORY_DEPTH flow tuples, plus write-pointer and fill-count metadata. It then passes the packet through unchanged and records that packet's tuple into a ring buffer. It sits after the tuple parser and before the output queues, and adds a bypass mode, a clear control and a packet counter.

## Interface
- C_S_AXIS_DATA_WIDTH, 512, input data width; must equal C_M_AXIS_DATA_WIDTH
- C_M_AXIS_DATA_WIDTH, 512, output data width
- C_S_AXIS_TUSER_WIDTH / C_M_AXIS_TUSER_WIDTH, 128, tuser widths; must be equal
- TUPLE_WIDTH, 112, width of one history entry
- HISTORY_DEPTH, 16, number of ring entries; power of 2, range 2..256
- Derived: TPB = DATA_WIDTH/TUPLE_WIDTH (integer division), HDR_BEATS = ceil(HISTORY_DEPTH/TPB), PW = log2(HISTORY_DEPTH); elaboration requires DATA_WIDTH - TPB*TUPLE_WIDTH >= 17
- axis_aclk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  per params  packet input
- s_axis_tready  out  1  input ready
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  per params  packet output
- m_axis_tready  in  1  output ready
- s_tuple  in  TUPLE_WIDTH  tuple for the packet currently at the input head
- s_tuple_valid  in  1  s_tuple valid
- s_tuple_ready  out  1  one-cycle pop of s_tuple
- hist_en  in  1  1 = prepend header; 0 = bypass; sampled only in IDLE
- hist_clear  in  1  synchronous pulse; empties the history
- hdr_pkt_count  out  32  count of packets emitted with a header; wraps

## Operation
- States: IDLE, HDR, PASS.
- IDLE: waits for s_axis_tvalid && s_tuple_valid.
  - If hist_en=1: go to HDR with beat_cnt=0.
  - If hist_en=0: go to PASS.
  - No output activity in IDLE.
- HDR:
  - m_axis_tvalid=1, tkeep all ones, tlast=0, tuser = s_axis_tuser of the held first packet beat.
  - Beat b, slot s (s<TPB) carries mem[b*TPB+s] at bits [(s+1)*TUPLE_WIDTH-1 : s*TUPLE_WIDTH]. Entries beyond HISTORY_DEPTH are zero.
  - Beat 0 only, at base B=TPB*TUPLE_WIDTH: [B+7:B] = wr_ptr zero-extended; [B+16:B+8] = fill count (0..HISTORY_DEPTH).
  - All other bits are zero.
  - On m_axis_tready: beat_cnt++. At beat HDR_BEATS-1, go to PASS and increment hdr_pkt_count.
- PASS:
  - m_axis_* = s_axis_* combinationally; s_axis_tready = m_axis_tready.
  - On a handshake with s_axis_tlast=1: mem[wr_ptr] <= s_tuple; wr_ptr <= wr_ptr+1 (wraps modulo HISTORY_DEPTH); count <= min(count+1, HISTORY_DEPTH); s_tuple_ready=1 that cycle; go to IDLE.
  - Tuples are recorded in bypass mode too.
- The header is a snapshot of history before the current packet; the current tuple is never included in its own header.
- hist_clear: next edge sets wr_ptr=0, count=0 and every mem entry to 0.
  - If it coincides with a commit, clear wins and the tuple is discarded, but it is still popped.
  - A clear during HDR takes effect immediately on the remaining header beats.
- s_axis_tready=0 in IDLE and HDR; the input is never consumed before its header completes.

## Timing
- Reset values: state=IDLE, wr_ptr=0, count=0, mem all zero, hdr_pkt_count=0, m_axis_tvalid=0, s_axis_tready=0, s_tuple_ready=0.
- One bubble cycle in IDLE per packet. The first header beat is valid on the cycle after the IDLE condition holds.
- Header overhead: HDR_BEATS handshakes. PASS is zero-latency combinational pass-through.
- m_axis_tvalid held while m_axis_tready=0; header data stable under backpressure.
- Single-beat packet (tlast on first beat): commit and return to IDLE in the same cycle; the next packet is eligible one cycle later.
- Reset asserted mid-packet: return immediately to reset values. The partially sent packet is truncated; downstream recovers on tlast.

## Test plan
- Defaults (512/112/16, TPB=4, HDR_BEATS=4), hist_en=1, first packet 3 beats, tuple A -> 4 header beats all-zero tuples with ptr=0, count=0; then 3 data beats unchanged; mem[0]=A; hdr_pkt_count=1.
- 17 one-beat packets, tuples T0..T16 -> 17th header: count=16, ptr=0, beat0 slot0=T0; after its commit, mem[0]=T16 and ptr=1.
- Random m_axis_tready (50%) on a 5-beat packet -> header and data beats stable while stalled; byte-exact output versus model.
- hist_en=0 with two packets -> no header beats; tuples still recorded; the next hist_en=1 header shows count=2; hdr_pkt_count unchanged during bypass.
- hist_clear coincident with a tlast commit -> s_tuple_ready=1, count=0, ptr=0, all entries zero in the next header.
- HISTORY_DEPTH=4, DATA_WIDTH=256, TUPLE_WIDTH=112 (TPB=2, HDR_BEATS=2); reset asserted during PASS -> m_axis_tvalid=0 asynchronously, state IDLE, history empty.
